// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_responder
//  Description : Physical-memory line responder. Latches one read or write
//                request, answers with a single-cycle pmem_resp exactly
//                LATENCY cycles after the request was sampled, and keeps a
//                sticky protocol-violation flag and completion counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         protocol_err,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam int c_lines = 1 << INDEX_BITS;
  // BUSY lasts LATENCY-1 cycles; the countdown runs from LATENCY-2 to 0.
  localparam logic [7:0] c_cnt_init = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [7:0]              r_cnt;
  logic                    r_is_write;
  logic [INDEX_BITS-1:0]   r_index;
  logic [255:0]            r_wdata;
  logic [255:0]            r_rdata;
  logic                    r_err;
  logic [31:0]             r_rd_count;
  logic [31:0]             r_wr_count;
  logic [255:0]            r_mem [c_lines];

  logic                    w_req;
  logic                    w_err_set;
  logic                    w_op_write;
  logic [INDEX_BITS-1:0]   w_op_index;
  logic                    w_enter_resp;
  logic                    w_unused;

  // Byte offset and aliasing high bits play no part in line selection.
  assign w_unused = ^{pmem_address[31:INDEX_BITS+5], pmem_address[4:0]};

  // Next state, protocol-violation detection and the operation that is
  // about to reach RESP (live inputs when LATENCY=1 jumps straight from IDLE).
  always_comb begin
    w_next_state = r_state;
    w_req        = pmem_read | pmem_write;
    w_err_set    = 1'b0;
    w_op_write   = r_is_write;
    w_op_index   = r_index;
    case (r_state)
      S_IDLE: begin
        w_op_write = pmem_write;
        w_op_index = pmem_address[INDEX_BITS+4:5];
        w_err_set  = pmem_read & pmem_write;
        if (w_req) begin
          w_next_state = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_err_set = ~w_req;
        if (r_cnt == 8'd0) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);
  end

  // Control state, latched request, read data, sticky error and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_is_write <= 1'b0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (r_state == S_IDLE && w_req) begin
        r_is_write <= pmem_write;
        r_index    <= pmem_address[INDEX_BITS+4:5];
        r_wdata    <= pmem_wdata;
        r_cnt      <= c_cnt_init;
      end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_enter_resp && !w_op_write) begin
        r_rdata <= r_mem[w_op_index];
      end
      if (r_state == S_RESP) begin
        if (r_is_write) begin
          r_wr_count <= r_wr_count + 32'd1;
        end else begin
          r_rd_count <= r_rd_count + 32'd1;
        end
      end
    end
  end

  // Line store: written at the edge that ends a write's RESP cycle. Reset
  // drops the FSM to IDLE at once, so an aborted write never lands here.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_is_write) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  assign pmem_resp    = (r_state == S_RESP);
  assign pmem_rdata   = r_rdata;
  assign protocol_err = r_err;
  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_responder
//  Description : Directed self-checking bench for pmem_responder, using one
//                LATENCY=4 instance and one LATENCY=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]        rd    = '0;
  logic [1:0]        wr    = '0;
  logic [1:0][31:0]  addr  = '0;
  logic [1:0][255:0] wdata = '0;
  logic [1:0]        resp;
  logic [1:0]        err;
  logic [1:0][255:0] rdata;
  logic [1:0][31:0]  rdc;
  logic [1:0][31:0]  wrc;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  localparam logic [255:0] c_a5 = {32{8'hA5}};
  localparam logic [255:0] c_d0 = {8{32'h0D0D_0D00}};
  localparam logic [255:0] c_d1 = {8{32'hD1D1_1111}};
  localparam logic [255:0] c_d2 = {8{32'h2222_D2D2}};
  localparam logic [255:0] c_d3 = {8{32'h3333_D3D3}};
  localparam logic [255:0] c_e0 = {16{16'hE0E0}};
  localparam logic [255:0] c_e1 = {16{16'h1E1E}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.LATENCY(4), .INDEX_BITS(5)) u4 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .protocol_err(err[0]), .rd_count(rdc[0]),
    .wr_count(wrc[0])
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(5)) u1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .protocol_err(err[1]), .rd_count(rdc[1]),
    .wr_count(wrc[1])
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on instance s; optionally drop it (and scramble the address)
  // from cycle t+drop_at on. Checks latency and the single-cycle pulse.
  task automatic txn(input int s, input logic rd_i, input logic wr_i,
                     input logic [31:0] a, input logic [255:0] d,
                     input int drop_at, input int exp_lat, input string tag);
    int t;
    int lat;
    @(posedge clk); #1;
    rd[s] = rd_i; wr[s] = wr_i; addr[s] = a; wdata[s] = d;
    t = cyc;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (resp[s]) lat = cyc - t;
      else begin
        @(posedge clk); #1;
        if (drop_at > 0 && cyc - t == drop_at) begin
          rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'h20; wdata[s] = '1;
        end
      end
    end
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
    @(posedge clk); #1;
    rd[s] = 1'b0; wr[s] = 1'b0;
    @(negedge clk);
    check({tag, " single-cycle resp"}, 256'(resp[s]), 256'(0));
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1; rd = '0; wr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int t;
    int hits;
    // Reset values while rst is held.
    @(negedge clk);
    check("reset resp",  256'(resp[0]), 256'(0));
    check("reset rdata", rdata[0], 256'(0));
    check("reset err",   256'(err[0]), 256'(0));
    check("reset rdc",   256'(rdc[0]), 256'(0));
    check("reset wrc",   256'(wrc[0]), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then read of the same line, LATENCY=4.
    txn(0, 1'b0, 1'b1, 32'h40, c_a5, 0, 4, "wr 0x40");
    check("wr 0x40 wrc", 256'(wrc[0]), 256'(1));
    check("wr 0x40 rdc", 256'(rdc[0]), 256'(0));
    txn(0, 1'b1, 1'b0, 32'h40, '0, 0, 4, "rd 0x40");
    check("rd 0x40 rdata", rdata[0], c_a5);
    check("rd 0x40 rdc", 256'(rdc[0]), 256'(1));
    check("rd 0x40 wrc", 256'(wrc[0]), 256'(1));

    // Aliasing: high bits and byte offset ignored; writes leave rdata alone.
    txn(0, 1'b0, 1'b1, 32'h400, c_d1, 0, 4, "wr 0x400");
    check("rdata unchanged by write", rdata[0], c_a5);
    txn(0, 1'b1, 1'b0, 32'h1F, '0, 0, 4, "rd 0x1F");
    check("alias rdata", rdata[0], c_d1);
    check("no err yet", 256'(err[0]), 256'(0));
    txn(0, 1'b0, 1'b1, 32'h60, c_d0, 0, 4, "wr 0x60");

    // Simultaneous read+write is a write with a sticky error.
    txn(0, 1'b1, 1'b1, 32'h20, c_d2, 0, 4, "rw 0x20");
    check("rw err", 256'(err[0]), 256'(1));
    check("rw wrc", 256'(wrc[0]), 256'(4));
    check("rw rdc", 256'(rdc[0]), 256'(2));
    txn(0, 1'b1, 1'b0, 32'h20, '0, 0, 4, "rd 0x20");
    check("rd 0x20 rdata", rdata[0], c_d2);
    check("err sticky", 256'(err[0]), 256'(1));

    // Dropped request mid-BUSY still completes on the latched address.
    reset_pulse();
    check("err cleared", 256'(err[0]), 256'(0));
    txn(0, 1'b1, 1'b0, 32'h40, '0, 2, 4, "dropped rd");
    check("dropped err", 256'(err[0]), 256'(1));
    check("dropped rdata", rdata[0], c_a5);
    check("dropped rdc", 256'(rdc[0]), 256'(1));

    // Reset in the middle of a write aborts it.
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h60; wdata[0] = c_d3;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; rd = '0; wr = '0;
    #1;
    check("abort resp",  256'(resp[0]), 256'(0));
    check("abort rdata", rdata[0], 256'(0));
    check("abort err",   256'(err[0]), 256'(0));
    check("abort rdc",   256'(rdc[0]), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[0]) hits++;
    end
    check("abort no resp", 256'(hits), 256'(0));
    txn(0, 1'b1, 1'b0, 32'h60, '0, 0, 4, "rd 0x60");
    check("abort store kept", rdata[0], c_d0);
    check("abort wrc", 256'(wrc[0]), 256'(0));

    // LATENCY=1 instance: preload two lines, then back-to-back reads.
    txn(1, 1'b0, 1'b1, 32'h00, c_e0, 0, 1, "l1 wr 0x00");
    txn(1, 1'b0, 1'b1, 32'h20, c_e1, 0, 1, "l1 wr 0x20");
    @(posedge clk); #1;
    rd[1] = 1'b1; addr[1] = 32'h00;
    t = cyc;
    @(negedge clk);
    check("b2b resp t", 256'(resp[1]), 256'(0));
    @(negedge clk);
    check("b2b resp t+1", 256'(resp[1]), 256'(1));
    check("b2b cycle t+1", 256'(cyc - t), 256'(1));
    check("b2b rdata 0x00", rdata[1], c_e0);
    @(posedge clk); #1;
    addr[1] = 32'h20;
    @(negedge clk);
    check("b2b resp t+2", 256'(resp[1]), 256'(0));
    @(negedge clk);
    check("b2b resp t+3", 256'(resp[1]), 256'(1));
    check("b2b cycle t+3", 256'(cyc - t), 256'(3));
    check("b2b rdata 0x20", rdata[1], c_e1);
    @(posedge clk); #1;
    rd[1] = 1'b0;
    @(negedge clk);
    check("b2b rdc", 256'(rdc[1]), 256'(2));
    check("b2b wrc", 256'(wrc[1]), 256'(2));

    // Read counter wraps from all-ones to zero.
    @(posedge clk); #1;
    u1.r_rd_count = 32'hFFFF_FFFF;
    txn(1, 1'b1, 1'b0, 32'h00, '0, 0, 1, "l1 wrap rd");
    check("rdc wrap", 256'(rdc[1]), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
